// File: rtl/usb_rx_packet_parser_if.sv
// Stream bundle between the USB FIFO side and the packet parser.
// It carries the input word stream and the payload output stream toward the core.
interface usb_rx_packet_parser_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/usb_rx_packet_parser.sv
// Frames 16-bit USB words into {sync,len} / payload / XOR-checksum packets,
// streams the payload to the core and keeps saturating good/error/drop counters.
module usb_rx_packet_parser #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 64,
  parameter int         TIMEOUT_CYC = 1024,
  parameter int         CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  usb_rx_packet_parser_if.slave bus,
  output logic                 pkt_ok_o,
  output logic                 pkt_err_o,
  output logic [CNT_W-1:0]     good_cnt_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic [CNT_W-1:0]     sync_drop_cnt_o,
  output logic [7:0]           status_o
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_e;

  state_e           state_q, state_d;
  logic [7:0]       remaining_q, remaining_d;
  logic [15:0]      csum_q, csum_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [7:0]       last_lo_q, last_lo_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             pkt_ok_q, pkt_ok_d;
  logic             pkt_err_q, pkt_err_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [7:0]       status_q, status_d;
  logic             in_ready_c;
  logic             xfer;
  logic [7:0]       len;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign len = bus.in_data[7:0];

  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    remaining_d = remaining_q;
    csum_d      = csum_q;
    timer_d     = timer_q;
    last_lo_d   = last_lo_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    good_cnt_d  = good_cnt_q;
    err_cnt_d   = err_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    status_d    = status_q;

    // Only payload words need room in the output register; header and checksum are absorbed.
    in_ready_c = 1'b1;
    if (state_q == PAYLOAD) in_ready_c = bus.out_ready | ~out_valid_q;
    xfer = bus.in_valid & in_ready_c;

    if (bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      HUNT: begin
        timer_d = '0;
        if (xfer) begin
          if (bus.in_data[15:8] == SYNC_BYTE && len != 8'd0 &&
              {24'd0, len} <= 32'(MAX_LEN)) begin
            state_d     = PAYLOAD;
            remaining_d = len;
            csum_d      = bus.in_data;
          end else begin
            drop_cnt_d = sat_inc(drop_cnt_q);
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          out_data_d  = bus.in_data;
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == 8'd1);
          csum_d      = csum_q ^ bus.in_data;
          remaining_d = remaining_q - 8'd1;
          last_lo_d   = bus.in_data[7:0];
          timer_d     = '0;
          if (remaining_q == 8'd1) state_d = CHECK;
        end
      end
      CHECK: begin
        if (xfer) begin
          timer_d = '0;
          state_d = HUNT;
          if (bus.in_data == csum_q) begin
            pkt_ok_d   = 1'b1;
            good_cnt_d = sat_inc(good_cnt_q);
            status_d   = last_lo_q;
          end else begin
            pkt_err_d = 1'b1;
            err_cnt_d = sat_inc(err_cnt_q);
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // Idle timer covers both input gaps and output back-pressure; the output register still drains.
    if (state_q != HUNT && !xfer) begin
      if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
        timer_d   = '0;
        state_d   = HUNT;
        pkt_err_d = 1'b1;
        err_cnt_d = sat_inc(err_cnt_q);
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  // NOTE: all state, including the datapath registers, is reset so a mid-packet reset leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      remaining_q <= '0;
      csum_q      <= '0;
      timer_q     <= '0;
      last_lo_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      good_cnt_q  <= '0;
      err_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      status_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q     <= state_d;
      remaining_q <= remaining_d;
      csum_q      <= csum_d;
      timer_q     <= timer_d;
      last_lo_q   <= last_lo_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
      good_cnt_q  <= good_cnt_d;
      err_cnt_q   <= err_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      status_q    <= status_d;
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_data     = out_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_last     = out_last_q;
  assign pkt_ok_o         = pkt_ok_q;
  assign pkt_err_o        = pkt_err_q;
  assign good_cnt_o       = good_cnt_q;
  assign err_cnt_o        = err_cnt_q;
  assign sync_drop_cnt_o  = drop_cnt_q;
  assign status_o         = status_q;

endmodule

// File: tb/tb_usb_rx_packet_parser.sv
// Directed bench for usb_rx_packet_parser: good/bad packets, hunting, stalls,
// timeout, asynchronous reset and counter saturation.
module tb_usb_rx_packet_parser;

  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pkt_ok, pkt_err;
  logic [7:0] good_cnt, err_cnt, drop_cnt, status;

  int errors = 0;
  int checks = 0;
  int n_ok   = 0;
  int n_err  = 0;

  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];

  usb_rx_packet_parser_if bus();

  usb_rx_packet_parser #(
    .SYNC_BYTE(8'hA5), .MAX_LEN(64), .TIMEOUT_CYC(TIMEOUT), .CNT_W(8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .pkt_ok_o        (pkt_ok),
    .pkt_err_o       (pkt_err),
    .good_cnt_o      (good_cnt),
    .err_cnt_o       (err_cnt),
    .sync_drop_cnt_o (drop_cnt),
    .status_o        (status)
  );

  always #5 clk = ~clk;

  // Output monitor: a word is taken whenever valid and ready are both high before the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_last, bus.out_data});
      if (pkt_ok)  n_ok++;
      if (pkt_err) n_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] w);
    int n = 0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("send_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare_out(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] w;
    int ok0, err0;

    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_pkt_ok",    32'(pkt_ok),        32'd0);
    check("rst_good",      32'(good_cnt),      32'd0);
    check("rst_status",    32'(status),        32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: good packet; checksum = A503^0011^0022^0033 = A503.
    send(16'hA503); send(16'h0011); send(16'h0022); send(16'h0033); send(16'hA503);
    check("t1_ok_pulse",  32'(pkt_ok),  32'd1);
    check("t1_err_pulse", 32'(pkt_err), 32'd0);
    idle(1);
    check("t1_ok_one_cycle", 32'(pkt_ok), 32'd0);
    idle(2);
    exp_q.push_back({1'b0, 16'h0011});
    exp_q.push_back({1'b0, 16'h0022});
    exp_q.push_back({1'b1, 16'h0033});
    compare_out("t1_out");
    check("t1_good",   32'(good_cnt), 32'd1);
    check("t1_status", 32'(status),   32'h33);

    // Test 2: same packet with wrong checksum A520; status must stay 33.
    send(16'hA503); send(16'h0011); send(16'h0022); send(16'h0044); send(16'hA520);
    check("t2_err_pulse", 32'(pkt_err), 32'd1);
    check("t2_ok_pulse",  32'(pkt_ok),  32'd0);
    idle(1);
    check("t2_err_one_cycle", 32'(pkt_err), 32'd0);
    idle(2);
    exp_q.push_back({1'b0, 16'h0011});
    exp_q.push_back({1'b0, 16'h0022});
    exp_q.push_back({1'b1, 16'h0044});
    compare_out("t2_out");
    check("t2_err_cnt", 32'(err_cnt),  32'd1);
    check("t2_good",    32'(good_cnt), 32'd1);
    check("t2_status",  32'(status),   32'h33);

    // Test 3: bad sync, len 0 and len 65 are all dropped, then a good packet.
    send(16'h1234); send(16'hA500); send(16'hA541);
    idle(1);
    check("t3_drop", 32'(drop_cnt), 32'd3);
    send(16'hA503); send(16'h0011); send(16'h0022); send(16'h0033); send(16'hA503);
    idle(3);
    exp_q.push_back({1'b0, 16'h0011});
    exp_q.push_back({1'b0, 16'h0022});
    exp_q.push_back({1'b1, 16'h0033});
    compare_out("t3_out");
    check("t3_good", 32'(good_cnt), 32'd2);

    // Test 4: core stalls mid-payload; checksum = A504^0101^0202^0303^0404 = A100.
    send(16'hA504); send(16'h0101);
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("t4_stall_ready", 32'(bus.in_ready), 32'd0);
          check("t4_stall_hold",  32'(bus.out_data), 32'h0101);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join_none
    send(16'h0202); send(16'h0303); send(16'h0404); send(16'hA100);
    check("t4_ok_pulse", 32'(pkt_ok), 32'd1);
    idle(3);
    exp_q.push_back({1'b0, 16'h0101});
    exp_q.push_back({1'b0, 16'h0202});
    exp_q.push_back({1'b0, 16'h0303});
    exp_q.push_back({1'b1, 16'h0404});
    compare_out("t4_out");
    check("t4_good", 32'(good_cnt), 32'd3);

    // Test 5: timeout after one of two payload words; abort lands exactly TIMEOUT idle cycles later.
    err0 = n_err;
    send(16'hA502); send(16'h0777);
    idle(TIMEOUT - 1);
    check("t5_no_early_err", 32'(pkt_err), 32'd0);
    idle(1);
    check("t5_err_pulse", 32'(pkt_err), 32'd1);
    idle(2);
    check("t5_err_cnt",    32'(err_cnt),     32'd2);
    check("t5_err_pulses", 32'(n_err - err0), 32'd1);
    exp_q.push_back({1'b0, 16'h0777});
    compare_out("t5_out");
    send(16'hA501); send(16'h00C3); send(16'hA5C2);
    idle(3);
    exp_q.push_back({1'b1, 16'h00C3});
    compare_out("t5_next_out");
    check("t5_good",   32'(good_cnt), 32'd4);
    check("t5_status", 32'(status),   32'hC3);

    // Test 6: asynchronous reset in PAYLOAD, then 300 single-word packets to saturate GOOD_CNT.
    ok0 = n_ok;
    send(16'hA503); send(16'h0011);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_out_data",  32'(bus.out_data),  32'd0);
    check("t6_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("t6_rst_counts",    {8'd0, good_cnt, err_cnt, drop_cnt}, 32'd0);
    check("t6_rst_status",    32'(status),        32'd0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_no_pulse", 32'(n_ok - ok0), 32'd0);
    got_q.delete();
    for (int i = 0; i < 300; i++) begin
      w = {8'h00, 8'(i)};
      send(16'hA501); send(w); send(16'hA501 ^ w);
    end
    idle(3);
    check("t6_good_sat",   32'(good_cnt),    32'hFF);
    check("t6_ok_pulses",  32'(n_ok - ok0),  32'd300);
    check("t6_err_cnt",    32'(err_cnt),     32'd0);
    check("t6_status",     32'(status),      32'h2B);
    check("t6_out_count",  32'(got_q.size()), 32'd300);
    got_q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
